cls_vote_bridge: RTL and testbench
==================================

# cls_vote_bridge

Lockstep data-port voter and responder for the triple-core (ms, sl1, sl2) cluster. It takes the three cores' data-memory requests and forms a bitwise 2-of-3 majority. It issues one voted request to data memory and fans the single grant/response back to all three cores. Per-core disagreement is flagged, counted and reported, and stalled memory responses are timed out so the cores never hang.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in WAIT before a synthetic response (≥1)

Ports (X ∈ {ms, sl1, sl2}, one set each):
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- data_req_X  in  1  core request
- data_we_X  in  1  write enable
- data_be_X  in  4  byte enables
- data_addr_X  in  ADDR_W  address
- data_wdata_X  in  DATA_W  write data
- data_gnt_X  out  1  grant to core
- data_rvalid_X  out  1  response valid to core
- data_rdata_X  out  DATA_W  read data to core
- mem_req  out  1  voted request to memory
- mem_we  out  1  voted write enable
- mem_be  out  4  voted byte enables
- mem_addr  out  ADDR_W  voted address
- mem_wdata  out  DATA_W  voted write data
- mem_gnt  in  1  memory grant
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data
- fault_core  out  3  per-core disagreement pulse, bit2=ms, bit1=sl1, bit0=sl2
- fault_timeout  out  1  one-cycle pulse on synthetic response
- fault_cnt  out  8  saturating count of cycles with any fault_core bit set
- fault_clr  in  1  clears fault_cnt

## Operation
- Vote: v_req = maj(req); every bundle field {we,be,addr,wdata} voted bitwise.
- Core X disagrees when req_X ≠ v_req, or when v_req=1 and any field of X ≠ voted field. Write data is compared only when voted we=1.
- FSM states:
  - IDLE: if v_req, register the voted bundle into the mem_* payload and go to REQ.
  - REQ: mem_req=1 with a stable payload. data_gnt_X = mem_gnt for all X, combinational. On mem_gnt go to WAIT and clear the timer.
  - WAIT: mem_req=0; core req ignored. On mem_rvalid, data_rvalid_X=1 and data_rdata_X=mem_rdata for all X, combinational; go to IDLE. Otherwise the timer increments. When timer = TIMEOUT-1 without rvalid: data_rvalid_X=1, data_rdata_X=0, fault_timeout=1, go to IDLE.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.
- Disagreement sampling: only in IDLE and REQ. fault_core is registered, so it appears one cycle after the sampled cycle.
- fault_cnt: +1 per cycle with fault_core≠0, saturating at 255. If fault_clr and an increment occur in the same cycle, clear wins (result 0).
- Reset: state IDLE, timer 0. All outputs 0: mem_*, data_gnt_X, data_rvalid_X, data_rdata_X, fault_*, fault_cnt. Reset mid-transaction abandons it with no response to the cores.

## Timing
- Request latency: core req at cycle n → mem_req at n+1. Earliest data_gnt_X is n+1, when mem_gnt is combinationally high.
- Payload is held stable from REQ entry until grant.
- rvalid passes through with zero added latency.
- Back-to-back: a req present in the cycle rvalid is returned is sampled in IDLE the next cycle, giving a new mem_req one cycle later. Maximum throughput is one transaction per 3 cycles.
- Single-core fault, e.g. sl1 req=0 while ms and sl2 req=1: the transaction still proceeds, and sl1 also receives the gnt/rvalid.

## Structure
- Shared package cls_pkg: FSM state enum (IDLE, REQ, WAIT); request bundle struct {we, be, addr, wdata}; core index constants CORE_MS=2, CORE_SL1=1, CORE_SL2=0.
- Sub-module cls_maj3: parameterized-width bitwise majority, instantiated once per bundle field and once for req.

## Test plan
- All three cores read addr 0x100; mem_gnt at n+2, mem_rvalid at n+4 with rdata 0xDEADBEEF → every core sees gnt at n+2 and rvalid/rdata 0xDEADBEEF at n+4; fault_core=0.
- Write with sl2 addr 0x204 vs 0x200 on ms/sl1 → mem_addr=0x200; fault_core=3'b001 one cycle after sampling; fault_cnt increments.
- ms req=0, sl1/sl2 read 0x40 → transaction issued; fault_core=3'b100; all cores receive the response.
- Grant, then no rvalid for TIMEOUT=4 → synthetic rvalid with rdata 0 and fault_timeout pulse 4 cycles after grant; FSM back to IDLE.
- fault_cnt at 255 with a continued fault → stays 255. fault_clr asserted together with a fault → 0.
- rst asserted in WAIT → all outputs 0 next cycle; the late mem_rvalid is ignored.

Source files
------------

// File: rtl/cls_pkg.sv
// Shared types and constants for the lockstep data-port voter.
// Core indices give the bit position of each core in fault_core.
package cls_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam int CORE_MS  = 2;
  localparam int CORE_SL1 = 1;
  localparam int CORE_SL2 = 0;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cls_maj3.sv
// Bitwise 2-of-3 majority over a W-bit field.
// One instance per voted field of the core request.
module cls_maj3
  import cls_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/cls_vote_bridge.sv
// Votes three lockstep data ports into one memory request and fans
// the single grant/response back, flagging and counting disagreement.
module cls_vote_bridge
  import cls_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req_ms,
  input  logic              data_we_ms,
  input  logic [3:0]        data_be_ms,
  input  logic [ADDR_W-1:0] data_addr_ms,
  input  logic [DATA_W-1:0] data_wdata_ms,
  output logic              data_gnt_ms,
  output logic              data_rvalid_ms,
  output logic [DATA_W-1:0] data_rdata_ms,
  input  logic              data_req_sl1,
  input  logic              data_we_sl1,
  input  logic [3:0]        data_be_sl1,
  input  logic [ADDR_W-1:0] data_addr_sl1,
  input  logic [DATA_W-1:0] data_wdata_sl1,
  output logic              data_gnt_sl1,
  output logic              data_rvalid_sl1,
  output logic [DATA_W-1:0] data_rdata_sl1,
  input  logic              data_req_sl2,
  input  logic              data_we_sl2,
  input  logic [3:0]        data_be_sl2,
  input  logic [ADDR_W-1:0] data_addr_sl2,
  input  logic [DATA_W-1:0] data_wdata_sl2,
  output logic              data_gnt_sl2,
  output logic              data_rvalid_sl2,
  output logic [DATA_W-1:0] data_rdata_sl2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        fault_core,
  output logic              fault_timeout,
  output logic [7:0]        fault_cnt,
  input  logic              fault_clr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t state, state_nx;
  logic [TW-1:0] timer, timer_nx;

  logic              v_req, v_we;
  logic [3:0]        v_be;
  logic [ADDR_W-1:0] v_addr;
  logic [DATA_W-1:0] v_wdata;

  logic [2:0]        c_req, c_we, dis;
  logic [3:0]        c_be    [3];
  logic [ADDR_W-1:0] c_addr  [3];
  logic [DATA_W-1:0] c_wdata [3];

  logic              gnt, rvalid;
  logic [DATA_W-1:0] rdata;

  assign c_req[CORE_MS]    = data_req_ms;
  assign c_req[CORE_SL1]   = data_req_sl1;
  assign c_req[CORE_SL2]   = data_req_sl2;
  assign c_we[CORE_MS]     = data_we_ms;
  assign c_we[CORE_SL1]    = data_we_sl1;
  assign c_we[CORE_SL2]    = data_we_sl2;
  assign c_be[CORE_MS]     = data_be_ms;
  assign c_be[CORE_SL1]    = data_be_sl1;
  assign c_be[CORE_SL2]    = data_be_sl2;
  assign c_addr[CORE_MS]   = data_addr_ms;
  assign c_addr[CORE_SL1]  = data_addr_sl1;
  assign c_addr[CORE_SL2]  = data_addr_sl2;
  assign c_wdata[CORE_MS]  = data_wdata_ms;
  assign c_wdata[CORE_SL1] = data_wdata_sl1;
  assign c_wdata[CORE_SL2] = data_wdata_sl2;

  cls_maj3 #(.W(1)) u_req (
    .a(data_req_ms), .b(data_req_sl1),
    .c(data_req_sl2), .y(v_req)
  );

  cls_maj3 #(.W(1)) u_we (
    .a(data_we_ms), .b(data_we_sl1),
    .c(data_we_sl2), .y(v_we)
  );

  cls_maj3 #(.W(4)) u_be (
    .a(data_be_ms), .b(data_be_sl1),
    .c(data_be_sl2), .y(v_be)
  );

  cls_maj3 #(.W(ADDR_W)) u_addr (
    .a(data_addr_ms), .b(data_addr_sl1),
    .c(data_addr_sl2), .y(v_addr)
  );

  cls_maj3 #(.W(DATA_W)) u_wdata (
    .a(data_wdata_ms), .b(data_wdata_sl1),
    .c(data_wdata_sl2), .y(v_wdata)
  );

  // Per-core mismatch against the vote; wdata only matters on writes.
  always_comb begin
    dis = '0;
    for (int i = 0; i < 3; i++) begin
      dis[i] = (c_req[i] != v_req) |
               (v_req & ((c_we[i] != v_we) |
                         (c_be[i] != v_be) |
                         (c_addr[i] != v_addr) |
                         (v_we & (c_wdata[i] != v_wdata))));
    end
  end

  // State and response timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // Next state, handshake fan-out and the synthetic timeout response.
  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    mem_req       = 1'b0;
    gnt           = 1'b0;
    rvalid        = 1'b0;
    rdata         = '0;
    fault_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (v_req) state_nx = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        gnt     = mem_gnt;
        if (mem_gnt) begin
          state_nx = WAIT;
          timer_nx = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rvalid   = 1'b1;
          rdata    = mem_rdata;
          state_nx = IDLE;
        end else if (timer == TMAX) begin
          rvalid        = 1'b1;
          fault_timeout = 1'b1;
          state_nx      = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture the voted bundle on IDLE exit; held until the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && v_req) begin
      mem_we    <= v_we;
      mem_be    <= v_be;
      mem_addr  <= v_addr;
      mem_wdata <= v_wdata;
    end
  end

  // Disagreement pulse and saturating counter; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_core <= '0;
      fault_cnt  <= '0;
    end else begin
      fault_core <= (state != WAIT) ? dis : 3'b000;
      if (fault_clr)
        fault_cnt <= '0;
      else if (fault_core != 3'b000 && fault_cnt != 8'hFF)
        fault_cnt <= fault_cnt + 8'd1;
    end
  end

  assign data_gnt_ms     = gnt;
  assign data_gnt_sl1    = gnt;
  assign data_gnt_sl2    = gnt;
  assign data_rvalid_ms  = rvalid;
  assign data_rvalid_sl1 = rvalid;
  assign data_rvalid_sl2 = rvalid;
  assign data_rdata_ms   = rdata;
  assign data_rdata_sl1  = rdata;
  assign data_rdata_sl2  = rdata;

endmodule

// File: tb/tb_cls_vote_bridge.sv
// Scoreboard bench for cls_vote_bridge: an open-loop driver plays cores
// and memory; a negedge monitor pops expectations on grant/response.
module tb_cls_vote_bridge;
  import cls_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_req [3];
  req_t        c_b   [3];
  logic        mem_gnt, mem_rvalid, fault_clr;
  logic [31:0] mem_rdata;

  logic [2:0]  g, rv, fault_core;
  logic [31:0] rd_ms, rd_sl1, rd_sl2;
  logic        mem_req, mem_we, fault_timeout;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  fault_cnt;

  cls_vote_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_ms(c_req[CORE_MS]),
    .data_we_ms(c_b[CORE_MS].we),
    .data_be_ms(c_b[CORE_MS].be),
    .data_addr_ms(c_b[CORE_MS].addr),
    .data_wdata_ms(c_b[CORE_MS].wdata),
    .data_gnt_ms(g[2]),
    .data_rvalid_ms(rv[2]),
    .data_rdata_ms(rd_ms),
    .data_req_sl1(c_req[CORE_SL1]),
    .data_we_sl1(c_b[CORE_SL1].we),
    .data_be_sl1(c_b[CORE_SL1].be),
    .data_addr_sl1(c_b[CORE_SL1].addr),
    .data_wdata_sl1(c_b[CORE_SL1].wdata),
    .data_gnt_sl1(g[1]),
    .data_rvalid_sl1(rv[1]),
    .data_rdata_sl1(rd_sl1),
    .data_req_sl2(c_req[CORE_SL2]),
    .data_we_sl2(c_b[CORE_SL2].we),
    .data_be_sl2(c_b[CORE_SL2].be),
    .data_addr_sl2(c_b[CORE_SL2].addr),
    .data_wdata_sl2(c_b[CORE_SL2].wdata),
    .data_gnt_sl2(g[0]),
    .data_rvalid_sl2(rv[0]),
    .data_rdata_sl2(rd_sl2),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fault_core(fault_core),
    .fault_timeout(fault_timeout),
    .fault_cnt(fault_cnt), .fault_clr(fault_clr)
  );

  typedef struct {
    logic expect_g;
    req_t p;
    int   cyc;
  } gnt_e_t;

  typedef struct {
    logic [31:0] d;
    logic        to;
    logic [2:0]  flt;
    int          cyc;
  } rsp_e_t;

  gnt_e_t gq [$];
  rsp_e_t rq [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_fc = 0;
  logic [2:0] fault_seen = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s act=event exp=none cyc=%0d", nm, cyc);
  endtask

  // Monitor: grants and responses are popped from the scoreboard.
  always @(negedge clk) begin
    gnt_e_t ge;
    rsp_e_t re;
    if (!rst) begin
      fault_seen = fault_seen | fault_core;
      if (mem_gnt) begin
        if (gq.size() == 0) fail_now("gnt_unexpected");
        else begin
          ge = gq.pop_front();
          chk("gnt_cyc", 128'(cyc), 128'(ge.cyc));
          if (ge.expect_g) begin
            chk("mem_req", 128'(mem_req), 128'(1));
            chk("payload",
                128'({mem_we, mem_be, mem_addr, mem_wdata}),
                128'(ge.p));
            chk("data_gnt", 128'(g), 128'(3'b111));
          end else begin
            chk("stray_gnt", 128'({mem_req, g}), 128'(0));
          end
        end
      end
      if (rv != 3'b000) begin
        if (rq.size() == 0) fail_now("rvalid_unexpected");
        else begin
          re = rq.pop_front();
          chk("rsp_cyc", 128'(cyc), 128'(re.cyc));
          chk("rvalid_all", 128'(rv), 128'(3'b111));
          chk("rdata",
              128'({rd_ms, rd_sl1, rd_sl2}),
              128'({re.d, re.d, re.d}));
          chk("fault_timeout", 128'(fault_timeout), 128'(re.to));
          chk("fault_core", 128'(fault_seen), 128'(re.flt));
          fault_seen = 3'b000;
        end
      end else if (fault_timeout) begin
        fail_now("timeout_without_rvalid");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < 3; i++) begin
      c_req[i]     = 1'b1;
      c_b[i].we    = we;
      c_b[i].be    = be;
      c_b[i].addr  = a;
      c_b[i].wdata = wd;
    end
  endtask

  task automatic idle_cores();
    for (int i = 0; i < 3; i++) c_req[i] = 1'b0;
  endtask

  // Reference vote: a bit is 1 when at least two cores drive it to 1.
  function automatic req_t vote3(input req_t a, input req_t b,
                                 input req_t c);
    logic [$bits(req_t)-1:0] x, y, z, v;
    x = a;
    y = b;
    z = c;
    for (int i = 0; i < $bits(req_t); i++)
      v[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
    return req_t'(v);
  endfunction

  // One transaction: grant d cycles after REQ entry, response r cycles
  // into WAIT (r >= TO means memory never answers).
  task automatic run_txn(input int d, input int r,
                         input logic [31:0] rd, input int gap,
                         input bit stray);
    req_t v;
    logic vr;
    logic [2:0] ef;
    int gc;
    v  = vote3(c_b[0], c_b[1], c_b[2]);
    vr = (int'(c_req[0]) + int'(c_req[1]) + int'(c_req[2])) >= 2;
    for (int i = 0; i < 3; i++) begin
      ef[i] = (c_req[i] != vr) ||
              (vr && (c_b[i].we != v.we || c_b[i].be != v.be ||
                      c_b[i].addr != v.addr ||
                      (v.we && c_b[i].wdata != v.wdata)));
    end
    gc = cyc + 1 + d;
    gq.push_back('{1'b1, v, gc});
    if (ef != 3'b000) exp_fc += d + 2;
    step();
    repeat (d) step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    idle_cores();
    if (r < TO) begin
      rq.push_back('{rd, 1'b0, ef, gc + 1 + r});
      for (int i = 0; i < r; i++) begin
        if (i == 0 && stray) begin
          mem_gnt = 1'b1;
          gq.push_back('{1'b0, '0, cyc});
        end
        step();
        mem_gnt = 1'b0;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end else begin
      rq.push_back('{32'h0, 1'b1, ef, gc + TO});
      for (int i = 0; i < TO; i++) begin
        if (i == 0 && stray) begin
          mem_gnt = 1'b1;
          gq.push_back('{1'b0, '0, cyc});
        end
        step();
        mem_gnt = 1'b0;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      step();
      mem_rvalid = 1'b0;
    end
    repeat (gap) step();
  endtask

  initial begin
    int f, k, cap;
    req_t v;
    idle_cores();
    for (int i = 0; i < 3; i++) c_b[i] = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    fault_clr  = 1'b0;
    rst        = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_mem", 128'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}),
        128'(0));
    chk("reset_core", 128'({g, rv, rd_ms, rd_sl1, rd_sl2}), 128'(0));
    chk("reset_fault", 128'({fault_core, fault_timeout, fault_cnt}),
        128'(0));
    step();
    rst = 1'b0;
    step();

    set_all(1'b0, 4'hF, 32'h100, 32'h0);
    run_txn(1, 1, 32'hDEADBEEF, 1, 1'b0);

    set_all(1'b1, 4'h3, 32'h200, 32'h1234_5678);
    c_b[CORE_SL2].addr = 32'h204;
    run_txn(0, 0, 32'h0, 1, 1'b0);

    set_all(1'b0, 4'hF, 32'h40, 32'h0);
    c_req[CORE_MS] = 1'b0;
    run_txn(0, 2, 32'h0BAD_F00D, 0, 1'b1);

    set_all(1'b0, 4'hF, 32'h80, 32'h0);
    run_txn(0, 9, 32'h0, 2, 1'b1);

    step();
    chk("fault_cnt_directed", 128'(fault_cnt), 128'(exp_fc));

    c_req[CORE_MS] = 1'b1;
    repeat (270) step();
    chk("fault_cnt_sat", 128'(fault_cnt), 128'(255));
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    idle_cores();
    @(negedge clk);
    chk("fault_clr_wins", 128'(fault_cnt), 128'(0));
    repeat (3) step();
    fault_clr = 1'b1;
    step();
    fault_clr  = 1'b0;
    exp_fc     = 0;
    fault_seen = 3'b000;

    for (int t = 0; t < 60; t++) begin
      set_all(1'($urandom), 4'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        f = $urandom_range(0, 2);
        k = $urandom_range(0, 4);
        case (k)
          0: c_req[f] = 1'b0;
          1: c_b[f].addr ^= 32'(1) << $urandom_range(0, 31);
          2: c_b[f].wdata ^= 32'(1) << $urandom_range(0, 31);
          3: c_b[f].be ^= 4'(1) << $urandom_range(0, 3);
          default: c_b[f].we = ~c_b[f].we;
        endcase
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 5),
              $urandom, $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
    end
    repeat (3) step();
    cap = (exp_fc > 255) ? 255 : exp_fc;
    chk("fault_cnt_random", 128'(fault_cnt), 128'(cap));

    set_all(1'b0, 4'hF, 32'h300, 32'h0);
    v = vote3(c_b[0], c_b[1], c_b[2]);
    gq.push_back('{1'b1, v, cyc + 1});
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    idle_cores();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_wait_mem",
        128'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}), 128'(0));
    chk("rst_wait_core", 128'({g, rv, rd_ms, rd_sl1, rd_sl2}), 128'(0));
    chk("rst_wait_fault",
        128'({fault_core, fault_timeout, fault_cnt}), 128'(0));
    step();
    mem_rvalid = 1'b0;
    repeat (2) step();

    chk("gq_left", 128'(gq.size()), 128'(0));
    chk("rq_left", 128'(rq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
